// File: rtl/ga20_sample_cache.sv
// GA20 sample cache: one 8-byte line per GA20 channel, refilled from the shared
// SDRAM ROM port with one aligned 64-bit request per miss.
module ga20_sample_cache #(
    parameter int                MEM_AW = 25,
    parameter logic [MEM_AW-1:0] BASE   = 25'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              sample_rd,
    input  logic [2:0]        sample_index,
    input  logic [19:0]       sample_addr,
    output logic              sample_valid,
    output logic [7:0]        sample_din,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [63:0]       mem_data
);

    typedef enum logic {
        IDLE,
        REQ
    } fill_state_e;

    fill_state_e state_q, state_d;

    logic [1:0]  ch;
    logic        hit;
    logic [7:0]  hit_byte;
    logic        start_fill;
    logic        finish_fill;

    logic [3:0]  valid_q;
    logic [16:0] tag_q  [4];
    logic [63:0] line_q [4];

    logic [1:0]  fill_ch_q;
    logic [16:0] fill_tag_q;
    logic        discard_q;

    // Step indices 1,2 share channel 0 and so on; index 0 wraps to channel 3.
    assign ch       = 2'((sample_index - 3'd1) >> 1);
    assign hit      = sample_rd && valid_q[ch] && (tag_q[ch] == sample_addr[19:3]);
    assign hit_byte = line_q[ch][{sample_addr[2:0], 3'b000} +: 8];
    assign mem_req  = (state_q == REQ);

    always_comb begin
        state_d     = state_q;
        start_fill  = 1'b0;
        finish_fill = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_rd && !hit) begin
                    start_fill = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    finish_fill = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush seen at any point during a fill poisons that fill's data.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_din   <= 8'h00;
            valid_q      <= 4'b0000;
            fill_ch_q    <= 2'd0;
            fill_tag_q   <= 17'd0;
            discard_q    <= 1'b0;
            mem_addr     <= BASE;
        end else begin
            sample_valid <= hit;
            if (hit) begin
                sample_din <= hit_byte;
            end
            if (start_fill) begin
                fill_ch_q  <= ch;
                fill_tag_q <= sample_addr[19:3];
                discard_q  <= flush;
                mem_addr   <= BASE + MEM_AW'({sample_addr[19:3], 3'b000});
            end else if (flush) begin
                discard_q <= 1'b1;
            end
            if (flush) begin
                valid_q <= 4'b0000;
            end else if (finish_fill && !discard_q) begin
                valid_q[fill_ch_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && finish_fill && !flush && !discard_q) begin
            tag_q[fill_ch_q]  <= fill_tag_q;
            line_q[fill_ch_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_ga20_sample_cache.sv
// Testbench for ga20_sample_cache: behavioural cache model feeding a scoreboard,
// plus directed checks for each scenario of the cache.
module tb_ga20_sample_cache;

    localparam int          MEM_AW = 25;
    localparam logic [24:0] BASE   = 25'h0100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        sample_rd;
    logic [2:0]  sample_index;
    logic [19:0] sample_addr;
    logic        sample_valid;
    logic [7:0]  sample_din;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_data;

    always #5 clk = ~clk;

    ga20_sample_cache #(
        .MEM_AW(MEM_AW),
        .BASE  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .sample_rd   (sample_rd),
        .sample_index(sample_index),
        .sample_addr (sample_addr),
        .sample_valid(sample_valid),
        .sample_din  (sample_din),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    typedef struct packed {
        logic        valid;
        logic [7:0]  din;
        logic        req;
        logic [24:0] addr;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic        m_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [16:0] m_tag   [4];
    logic [63:0] m_line  [4];
    logic        m_busy    = 1'b0;
    logic        m_discard = 1'b0;
    logic [1:0]  m_fill_ch  = 2'd0;
    logic [16:0] m_fill_tag = 17'd0;
    logic [7:0]  m_din  = 8'h00;
    logic [24:0] m_addr = BASE;

    bit   auto_mem  = 1'b0;
    int   ack_wait  = 0;
    int   req_count = 0;
    logic prev_req  = 1'b0;

    function automatic logic [1:0] chan(input logic [2:0] idx);
        case (idx)
            3'd1, 3'd2: return 2'd0;
            3'd3, 3'd4: return 2'd1;
            3'd5, 3'd6: return 2'd2;
            default:    return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] rom_byte(input logic [24:0] m);
        return m[7:0] ^ {m[12:8], 3'b101};
    endfunction

    function automatic logic [63:0] rom_line(input logic [24:0] m);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = rom_byte(m + 25'(k));
        return d;
    endfunction

    task automatic drive(input logic rd, input logic [2:0] idx, input logic [19:0] a);
        sample_rd    = rd;
        sample_index = idx;
        sample_addr  = a;
    endtask

    // One clock: model predicts, scoreboard holds the prediction, DUT is compared after the edge.
    task automatic tick();
        exp_t       e;
        exp_t       got;
        logic [1:0] c;
        logic       hit;
        if (auto_mem) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (ack_wait == 2) begin
                    mem_ack  = 1'b1;
                    mem_data = rom_line(mem_addr);
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
        c   = chan(sample_index);
        hit = sample_rd && m_valid[c] && (m_tag[c] == sample_addr[19:3]);
        if (reset) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
            m_din     = 8'h00;
            m_addr    = BASE;
            for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
            e.valid = 1'b0;
        end else begin
            e.valid = hit;
            if (hit) m_din = m_line[c][{sample_addr[2:0], 3'b000} +: 8];
            if (!m_busy) begin
                if (sample_rd && !hit) begin
                    m_busy     = 1'b1;
                    m_fill_ch  = c;
                    m_fill_tag = sample_addr[19:3];
                    m_addr     = BASE + {5'b0, sample_addr[19:3], 3'b000};
                    m_discard  = flush;
                end
            end else if (mem_ack) begin
                if (!flush && !m_discard) begin
                    m_valid[m_fill_ch] = 1'b1;
                    m_tag[m_fill_ch]   = m_fill_tag;
                    m_line[m_fill_ch]  = mem_data;
                end
                m_busy = 1'b0;
            end else if (flush) begin
                m_discard = 1'b1;
            end
            if (flush) for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
        end
        e.din  = m_din;
        e.req  = m_busy;
        e.addr = m_addr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        tests_run += 4;
        if (sample_valid !== got.valid) begin
            tests_failed++;
            $display("[TB] FAIL sb_sample_valid: got %b expected %b", sample_valid, got.valid);
        end
        if (sample_din !== got.din) begin
            tests_failed++;
            $display("[TB] FAIL sb_sample_din: got %h expected %h", sample_din, got.din);
        end
        if (mem_req !== got.req) begin
            tests_failed++;
            $display("[TB] FAIL sb_mem_req: got %b expected %b", mem_req, got.req);
        end
        if (mem_addr !== got.addr) begin
            tests_failed++;
            $display("[TB] FAIL sb_mem_addr: got %h expected %h", mem_addr, got.addr);
        end
        if (mem_req === 1'b1 && prev_req !== 1'b1) req_count++;
        prev_req = mem_req;
    endtask

    task automatic ack_cycle(input logic [63:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_data = 64'h0;
        drive(1'b0, 3'd1, 20'h0);
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (mem_addr !== BASE || mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got req=%b addr=%h expected req=0 addr=%h", mem_req, mem_addr, BASE);
        end
    endtask

    task automatic test_cold_miss();
        drive(1'b1, 3'd1, 20'h01234);
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== BASE + 25'h01230) begin
            tests_failed++;
            $display("[TB] FAIL cold_req: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, BASE + 25'h01230);
        end
        drive(1'b0, 3'd1, 20'h0);
        tick();
        drive(1'b1, 3'd2, 20'h01234);
        ack_cycle(64'h0807060504030201);
        tests_run++;
        if (sample_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ack_same_cycle: got valid=%b expected 0", sample_valid);
        end
        drive(1'b1, 3'd1, 20'h01234);
        tick();
        tests_run++;
        if (sample_valid !== 1'b1 || sample_din !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL cold_hit: got valid=%b din=%h expected valid=1 din=05", sample_valid, sample_din);
        end
    endtask

    task automatic test_channel_map();
        drive(1'b1, 3'd0, 20'h00010);
        tick();
        drive(1'b0, 3'd0, 20'h0);
        ack_cycle(64'hA7A6A5A4A3A2A1A0);
        drive(1'b1, 3'd7, 20'h00010);
        tick();
        tests_run++;
        if (sample_valid !== 1'b1 || sample_din !== 8'hA0) begin
            tests_failed++;
            $display("[TB] FAIL map_idx7_hit: got valid=%b din=%h expected valid=1 din=a0", sample_valid, sample_din);
        end
        drive(1'b1, 3'd1, 20'h00010);
        tick();
        tests_run++;
        if (sample_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== BASE + 25'h10) begin
            tests_failed++;
            $display("[TB] FAIL map_ch0_miss: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h",
                     sample_valid, mem_req, mem_addr, BASE + 25'h10);
        end
        drive(1'b0, 3'd1, 20'h0);
        ack_cycle(64'hB7B6B5B4B3B2B1B0);
    endtask

    task automatic test_busy_drop();
        drive(1'b1, 3'd2, 20'h02000);
        tick();
        drive(1'b1, 3'd3, 20'h03000);
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== BASE + 25'h02000) begin
            tests_failed++;
            $display("[TB] FAIL busy_drop: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, BASE + 25'h02000);
        end
        drive(1'b0, 3'd3, 20'h0);
        ack_cycle(64'h1111111111111111);
        tests_run++;
        if (mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL req_drop_after_ack: got %b expected 0", mem_req);
        end
        drive(1'b1, 3'd4, 20'h03000);
        tick();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== BASE + 25'h03000) begin
            tests_failed++;
            $display("[TB] FAIL busy_retry: got req=%b addr=%h expected req=1 addr=%h", mem_req, mem_addr, BASE + 25'h03000);
        end
        drive(1'b0, 3'd4, 20'h0);
        ack_cycle(64'hC7C6C5C4C3C2C1C0);
        drive(1'b1, 3'd3, 20'h03005);
        tick();
        tests_run++;
        if (sample_valid !== 1'b1 || sample_din !== 8'hC5) begin
            tests_failed++;
            $display("[TB] FAIL busy_ch1_hit: got valid=%b din=%h expected valid=1 din=c5", sample_valid, sample_din);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 3'd5, 20'h04000);
        tick();
        drive(1'b0, 3'd5, 20'h0);
        tick();
        flush = 1'b1;
        ack_cycle(64'h2222222222222222);
        flush = 1'b0;
        drive(1'b1, 3'd5, 20'h04000);
        tick();
        tests_run++;
        if (sample_valid !== 1'b0 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_ack: got valid=%b req=%b expected valid=0 req=1", sample_valid, mem_req);
        end
        drive(1'b0, 3'd5, 20'h0);
        ack_cycle(64'h3333333333333333);
        drive(1'b1, 3'd6, 20'h05000);
        tick();
        flush = 1'b1;
        drive(1'b0, 3'd6, 20'h0);
        tick();
        flush = 1'b0;
        ack_cycle(64'h4444444444444444);
        drive(1'b1, 3'd6, 20'h05000);
        tick();
        tests_run++;
        if (sample_valid !== 1'b0 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_in_req: got valid=%b req=%b expected valid=0 req=1", sample_valid, mem_req);
        end
        drive(1'b0, 3'd6, 20'h0);
        ack_cycle(64'h5555555555555555);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd7, 20'h06000);
        tick();
        reset = 1'b1;
        drive(1'b0, 3'd7, 20'h0);
        tick();
        reset = 1'b0;
        tests_run++;
        if (mem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_req: got %b expected 0", mem_req);
        end
        ack_cycle(64'h6666666666666666);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(7 + i), 20'h06000);
            tick();
            tests_run++;
            if (sample_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stray_ack_idx%0d: got valid=%b expected 0", (7 + i) % 8, sample_valid);
            end
        end
        drive(1'b0, 3'd1, 20'h0);
        ack_cycle(64'h7777777777777777);
    endtask

    // Stream 24 bytes across the top of the address space; each drained line prefetches the next.
    task automatic test_streaming();
        logic [19:0] a;
        bit          got;
        auto_mem  = 1'b1;
        ack_wait  = 0;
        req_count = 0;
        a = 20'hFFFF0;
        for (int i = 0; i < 24; i++) begin
            got = 1'b0;
            for (int t = 0; t < 16 && !got; t++) begin
                drive(1'b1, 3'd1, a);
                tick();
                if (sample_valid === 1'b1) begin
                    got = 1'b1;
                    tests_run++;
                    if (sample_din !== rom_byte(BASE + {5'b0, a})) begin
                        tests_failed++;
                        $display("[TB] FAIL stream_byte_%0d: got %h expected %h", i, sample_din, rom_byte(BASE + {5'b0, a}));
                    end
                end
            end
            if (!got) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL stream_timeout_%0d: got no valid byte expected valid=1", i);
            end
            if (i % 8 == 7 && i != 23) begin
                drive(1'b1, 3'd2, a + 20'd8);
                tick();
            end
            a = a + 20'd1;
        end
        drive(1'b0, 3'd1, 20'h0);
        repeat (4) tick();
        auto_mem = 1'b0;
        mem_ack  = 1'b0;
        tests_run++;
        if (req_count != 3) begin
            tests_failed++;
            $display("[TB] FAIL stream_req_count: got %0d expected 3", req_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_channel_map();
        test_busy_drop();
        test_flush();
        test_reset_mid();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ga20_sample_cache.md
# ga20_sample_cache

Per-channel line cache between the GA20 sound block's sample port and the shared SDRAM ROM port. It holds one 8-byte line per GA20 channel and answers the GA20's byte lookups from those lines. On a miss it issues one aligned 64-bit burst request to memory. The GA20 re-presents each channel address every step pair and prefetches `cur_addr+8`, so a miss is satisfied on a later presentation and never stalls the GA20.

## Interface
Parameters:
- `MEM_AW`, default 25: memory-side byte address width.
- `BASE`, default `25'h0`: byte offset of the GA20 sample ROM in memory space.

Ports:
- `clk`  in  1: system clock. One clock domain for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `flush`  in  1: one-cycle pulse; invalidates all lines (ROM reload).
- `sample_rd`  in  1: lookup enable from the GA20.
- `sample_index`  in  3: GA20 step index; selects the channel.
- `sample_addr`  in  20: byte address from the GA20.
- `sample_valid`  out  1: registered; high when `sample_din` is valid for the previous cycle's lookup.
- `sample_din`  out  8: registered sample byte.
- `mem_req`  out  1: level request, held until acked.
- `mem_addr`  out  `MEM_AW`: `BASE + {line_addr, 3'b000}`; stable while `mem_req` is high.
- `mem_ack`  in  1: one-cycle pulse; `mem_data` is valid in that cycle.
- `mem_data`  in  64: line data. Byte k = `mem_data[8k+7:8k]`.

## Operation
- Channel select: `ch = (sample_index - 3'd1) >> 1`, so index 1,2 → ch0; 3,4 → ch1; 5,6 → ch2; 7,0 → ch3.
- Per-channel state: `tag[ch]` (17 bits, = `addr[19:3]`), `valid[ch]`, and `line[ch]` (64 bits).
- Hit: `sample_rd & valid[ch] & tag[ch]==sample_addr[19:3]`. Next cycle: `sample_valid=1` and `sample_din = line[ch]` byte `sample_addr[2:0]`.
- Miss, or `sample_rd=0`: next cycle `sample_valid=0`; `sample_din` holds its last value.
- Fill FSM states: IDLE and REQ.
  - IDLE: on a miss with `sample_rd=1`, latch `fill_ch=ch` and `fill_tag=sample_addr[19:3]`, raise `mem_req`, go to REQ.
  - REQ: hold `mem_req`. On `mem_ack`: write `line[fill_ch]=mem_data`, `tag[fill_ch]=fill_tag`, `valid[fill_ch]=1`, drop `mem_req`, return to IDLE.
  - `mem_req` goes low in the cycle after the ack. A new request may be raised the cycle after that.
- Only one fill is outstanding at a time. Misses detected while in REQ are dropped and are re-detected on the channel's next presentation.
- A fill replaces only the `fill_ch` line, even if another channel's tag matches the same line address. Two channels may hold the same line independently.
- Boundaries:
  - Lookup in the same cycle as `mem_ack` for the filling channel uses the old contents (miss). It hits from the next presentation on.
  - `flush` clears all `valid` bits. If `flush` and `mem_ack` coincide, the fill data is discarded (`valid` stays 0) and the FSM still returns to IDLE.
  - `flush` in REQ without an ack: the FSM stays in REQ, and the eventual fill is discarded.
  - Reset mid-request: `mem_req` drops at the reset edge. The memory side must tolerate an abandoned request; a stray later `mem_ack` in IDLE is ignored.
  - Address wrap: line `0x1FFFF` + 8 bytes wraps within the 20-bit address space. No special handling.

## Timing
- Reset values:
  - `sample_valid=0`, `sample_din=0`, `mem_req=0`, `mem_addr=BASE`.
  - FSM in IDLE, all `valid=0`.
  - `tag` and `line` contents are don't-care.
- Hit latency: 1 clock from `sample_addr`/`sample_index` to `sample_valid`/`sample_din`.
- Miss to `mem_req`: `mem_req` is high 1 clock after the missing lookup.
- Ack to hit: a lookup one clock after `mem_ack` hits. Total miss penalty = memory latency + 2 clocks.
- Handshake: `mem_addr` changes only in IDLE. In IDLE, a `mem_ack` is ignored.

## Test plan
- Cold miss then hit: reset; present index=1, addr=`0x01234`. Required: `mem_req` next cycle with `mem_addr=BASE+0x01230`. Ack with `mem_data=64'h0807060504030201`. Re-present: `sample_valid=1`, `sample_din=0x05`.
- Channel mapping: fill ch3 via index=0 at addr `0x00010`, then present index=7 at the same addr. Required: hit. Present index=1 at the same addr: miss, and `mem_req` is raised for ch0.
- Busy drop: while REQ is pending for ch0, present a miss on ch1. Required: no second request and no change to `mem_addr`. After ch0's ack, ch1's next presentation raises `mem_req` for ch1's line.
- Flush/ack collision: assert `flush` and `mem_ack` in the same cycle. Required: the following lookup misses, `sample_valid=0`, and a new `mem_req` is raised.
- Reset mid-request: assert `reset` while `mem_req=1`. Required: `mem_req=0` the next cycle. A stray `mem_ack` afterwards yields no hit on any channel.
- GA20 streaming: run a ch0 sequential stream of 24 bytes with the GA20 prefetch pattern (addr, then addr+8). Required: every byte is eventually returned with `sample_valid=1` and the correct value, with exactly 3 memory requests.
